// File: rtl/flo_dispatch.sv
// Instruction fetch/dispatch: reads words from a 2-cycle BRAM, decodes them and
// strobes one of num_ch timed output buffers. Optional FLO_DISPATCH_STALL_COUNT_EN adds stall_cnt_o.
module flo_dispatch #(
    parameter int num_ch = 8,
    parameter int addr_w = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [addr_w-1:0] start_addr_i,
    output logic [addr_w-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [31:0]       mem_data_i,
    input  logic [num_ch-1:0] full_i,
    output logic [15:0]       data_o,
    output logic [6:0]        delay_o,
    output logic [num_ch-1:0] valid_o,
    output logic [num_ch-1:0] direct_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              err_o
`ifdef FLO_DISPATCH_STALL_COUNT_EN
    ,output logic [31:0]      stall_cnt_o
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_DISP = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    logic [2:0]        state, nxt;
    logic [addr_w-1:0] pc, pc_nxt;
    logic [31:0]       instr;
    logic [7:0]        ch;
    logic              dir, ch_ok, tgt_full;
    logic              go_valid, go_direct, set_err, clr_err, stall;
    logic [num_ch-1:0] ch_sel;

    assign ch    = instr[23:16];
    assign dir   = instr[31];
    assign ch_ok = ({24'd0, ch} < num_ch);

    genvar g;
    generate
        for (g = 0; g < num_ch; g++) begin : g_sel
            assign ch_sel[g] = (ch == 8'(g));
        end
    endgenerate

    assign tgt_full   = |(full_i & ch_sel);
    assign mem_addr_o = pc;

    always_comb begin
        nxt       = state;
        pc_nxt    = pc;
        go_valid  = 1'b0;
        go_direct = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        stall     = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    nxt     = S_READ;
                    pc_nxt  = start_addr_i;
                    clr_err = 1'b1;
                end
            end
            S_READ: nxt = S_WAIT;
            S_WAIT: nxt = S_CAPT;
            S_CAPT: nxt = S_DISP;
            S_DISP: begin
                if (ch == 8'hFF) begin
                    nxt = S_HALT;
                end else if (ch == 8'hFE) begin
                    nxt    = S_READ;
                    pc_nxt = addr_w'(instr[15:0]);
                end else if (!ch_ok) begin
                    nxt     = S_READ;
                    pc_nxt  = pc + addr_w'(1);
                    set_err = 1'b1;
                end else if (dir) begin
                    nxt       = S_READ;
                    pc_nxt    = pc + addr_w'(1);
                    go_direct = 1'b1;
                end else if (tgt_full) begin
                    stall = 1'b1;
                end else begin
                    nxt      = S_READ;
                    pc_nxt   = pc + addr_w'(1);
                    go_valid = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
        // stop discards whatever this cycle would have done, including a start
        if (stop_i) begin
            nxt       = S_IDLE;
            pc_nxt    = pc;
            go_valid  = 1'b0;
            go_direct = 1'b0;
            set_err   = 1'b0;
            clr_err   = 1'b0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            instr    <= '0;
            mem_rd_o <= 1'b0;
            data_o   <= '0;
            delay_o  <= '0;
            valid_o  <= '0;
            direct_o <= '0;
            busy_o   <= 1'b0;
            halted_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= nxt;
            pc       <= pc_nxt;
            if (state == S_CAPT) instr <= mem_data_i;
            mem_rd_o <= (nxt == S_READ);
            busy_o   <= (nxt != S_IDLE) && (nxt != S_HALT);
            halted_o <= (nxt == S_HALT);
            valid_o  <= go_valid  ? ch_sel : '0;
            direct_o <= go_direct ? ch_sel : '0;
            if (go_valid || go_direct) begin
                data_o  <= instr[15:0];
                delay_o <= instr[30:24];
            end
            if (clr_err)      err_o <= 1'b0;
            else if (set_err) err_o <= 1'b1;
        end
    end

`ifdef FLO_DISPATCH_STALL_COUNT_EN
    // clr_err doubles as "start accepted"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           stall_cnt_o <= '0;
        else if (clr_err)                     stall_cnt_o <= '0;
        else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_flo_dispatch.sv
// Bench for flo_dispatch: cycle table for a basic program, directed corner
// sequences, and randomized programs against a transaction-level model.
module tb_flo_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, stop_i;
    logic [15:0] start_addr_i;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic [31:0] mem_data_i;
    logic [7:0]  full_i;
    logic [15:0] data_o;
    logic [6:0]  delay_o;
    logic [7:0]  valid_o, direct_o;
    logic        busy_o, halted_o, err_o;
`ifdef FLO_DISPATCH_STALL_COUNT_EN
    logic [31:0] stall_cnt_o;
`endif

    flo_dispatch #(.num_ch(8), .addr_w(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .start_addr_i(start_addr_i), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
        .mem_data_i(mem_data_i), .full_i(full_i), .data_o(data_o), .delay_o(delay_o),
        .valid_o(valid_o), .direct_o(direct_o), .busy_o(busy_o), .halted_o(halted_o),
        .err_o(err_o)
`ifdef FLO_DISPATCH_STALL_COUNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model: data appears exactly two cycles after the read cycle, junk otherwise
    logic [31:0] mem [0:65535];
    logic        rd_d1;
    logic [31:0] dat_d1;
    always @(posedge clk) begin
        rd_d1      <= mem_rd_o;
        dat_d1     <= mem[mem_addr_o];
        mem_data_i <= rd_d1 ? dat_d1 : $urandom();
    end

    localparam logic [31:0] HALT_W = 32'h00FF_0000;

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  valid;
        logic [15:0] data;
        logic [6:0]  dly;
        logic        busy;
        logic        halted;
    } vec_t;
    vec_t tab [14];

    typedef struct {
        logic        dir;
        int          ch;
        logic [15:0] data;
        logic [6:0]  delay;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic logic [31:0] w(input logic d, input logic [6:0] dl,
                                      input logic [7:0] c, input logic [15:0] dt);
        return {d, dl, c, dt};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    // leaves the bench at the negedge of cycle 1 (the first READ cycle)
    task automatic start_at(input logic [15:0] a);
        start_addr_i = a;
        start_i = 1'b1;
        tick();
        cyc = 1;
        start_i = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (!halted_o && n < budget) begin
            tick();
            n++;
        end
        chk("halt_reached", 64'(halted_o), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = {1'b1, 16'h0, 8'h00, 16'h0, 7'd0, 1'b1, 1'b0};
        tab[1]  = {1'b0, 16'h0, 8'h00, 16'h0, 7'd0, 1'b1, 1'b0};
        tab[2]  = {1'b0, 16'h0, 8'h00, 16'h0, 7'd0, 1'b1, 1'b0};
        tab[3]  = {1'b0, 16'h0, 8'h00, 16'h0, 7'd0, 1'b1, 1'b0};
        tab[4]  = {1'b1, 16'h1, 8'h01, 16'h1, 7'd0, 1'b1, 1'b0};
        tab[5]  = {1'b0, 16'h1, 8'h00, 16'h1, 7'd0, 1'b1, 1'b0};
        tab[6]  = {1'b0, 16'h1, 8'h00, 16'h1, 7'd0, 1'b1, 1'b0};
        tab[7]  = {1'b0, 16'h1, 8'h00, 16'h1, 7'd0, 1'b1, 1'b0};
        tab[8]  = {1'b1, 16'h2, 8'h02, 16'h2, 7'd3, 1'b1, 1'b0};
        tab[9]  = {1'b0, 16'h2, 8'h00, 16'h2, 7'd3, 1'b1, 1'b0};
        tab[10] = {1'b0, 16'h2, 8'h00, 16'h2, 7'd3, 1'b1, 1'b0};
        tab[11] = {1'b0, 16'h2, 8'h00, 16'h2, 7'd3, 1'b1, 1'b0};
        tab[12] = {1'b0, 16'h2, 8'h00, 16'h2, 7'd3, 1'b0, 1'b1};
        tab[13] = {1'b0, 16'h2, 8'h00, 16'h2, 7'd3, 1'b0, 1'b1};

        for (int i = 0; i < 65536; i++) mem[i] = HALT_W;
        mem[16'h00] = w(1'b0, 7'd0, 8'd0, 16'h0001);
        mem[16'h01] = w(1'b0, 7'd3, 8'd1, 16'h0002);
        mem[16'h20] = w(1'b0, 7'd5, 8'd2, 16'h5555);
        mem[16'h30] = w(1'b1, 7'd0, 8'd3, 16'h04D2);
        mem[16'h40] = w(1'b0, 7'd0, 8'hFE, 16'h0010);
        mem[16'h10] = w(1'b0, 7'd0, 8'd0, 16'h2222);
        mem[16'h50] = w(1'b0, 7'd0, 8'd9, 16'h1111);
        mem[16'h51] = w(1'b0, 7'd0, 8'd1, 16'h3333);

        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; start_addr_i = '0; full_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {mem_rd_o, mem_addr_o, valid_o, direct_o, data_o, delay_o,
                            busy_o, halted_o, err_o}, 64'd0);
        rst_n = 1'b1;
        tick();

        // basic program, cycle by cycle
        start_at(16'h0000);
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) tick();
            chk($sformatf("basic_c%0d", c),
                {mem_rd_o, mem_addr_o, valid_o, data_o, delay_o, busy_o, halted_o}, tab[c-1]);
        end

        // stall on full channel 2 for ten dispatch cycles
        full_i = 8'h04;
        start_at(16'h0020);
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) tick();
            chk("stall_no_strobe", 64'(valid_o), 64'd0);
        end
        chk("stall_busy", 64'(busy_o), 64'd1);
        full_i = 8'h00;
        tick();
        chk("stall_release", {valid_o, data_o, delay_o}, {8'h04, 16'h5555, 7'd5});
        tick();
        chk("stall_one_shot", 64'(valid_o), 64'd0);
`ifdef FLO_DISPATCH_STALL_COUNT_EN
        chk("stall_cnt", 64'(stall_cnt_o), 64'd10);
`endif
        run_to_halt(20);

        // direct write ignores full
        full_i = 8'h08;
        start_at(16'h0030);
        wait_cyc(4);
        chk("direct_pre", 64'(direct_o), 64'd0);
        wait_cyc(5);
        chk("direct_strobe", {direct_o, valid_o, data_o}, {8'h08, 8'h00, 16'd1234});
        full_i = 8'h00;
        run_to_halt(20);

        // jump
        start_at(16'h0040);
        wait_cyc(5);
        chk("jump_read", {mem_rd_o, mem_addr_o, valid_o, direct_o}, {1'b1, 16'h0010, 8'h00, 8'h00});
        wait_cyc(9);
        chk("jump_target_word", {valid_o, data_o}, {8'h01, 16'h2222});
        run_to_halt(20);

        // bad channel sets sticky err, next word still dispatched
        start_at(16'h0050);
        wait_cyc(5);
        chk("err_set", {err_o, valid_o, direct_o, mem_addr_o}, {1'b1, 8'h00, 8'h00, 16'h0051});
        wait_cyc(9);
        chk("err_next_word", {err_o, valid_o, data_o}, {1'b1, 8'h02, 16'h3333});
        run_to_halt(20);
        chk("err_sticky", 64'(err_o), 64'd1);
        start_at(16'h0052);
        chk("err_cleared_by_start", 64'(err_o), 64'd0);
        run_to_halt(20);

        // stop during WAIT, then stop beating start in IDLE
        start_at(16'h0000);
        tick();
        stop_i = 1'b1; start_i = 1'b1;
        tick();
        chk("stop_idle", {busy_o, mem_rd_o, halted_o}, 64'd0);
        tick();
        chk("stop_beats_start", {busy_o, mem_rd_o}, 64'd0);
        stop_i = 1'b0; start_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("stop_no_strobe", {valid_o, direct_o, busy_o}, 64'd0);
        end

        // async reset mid-stall
        full_i = 8'h04;
        start_at(16'h0020);
        wait_cyc(8);
        chk("rst_pre_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {mem_rd_o, mem_addr_o, valid_o, direct_o, data_o, delay_o,
                          busy_o, halted_o, err_o}, 64'd0);
        full_i = 8'h00;
        tick();
        rst_n = 1'b1;
`ifdef FLO_DISPATCH_STALL_COUNT_EN
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rst_no_partial", {valid_o, direct_o, busy_o}, 64'd0);
        end

        // randomized programs against a transaction-level model
        for (int r = 0; r < 4; r++) begin
            int   base, nw, pc, n, ach;
            logic exp_err;
            logic [31:0] wd;
            wr_t  e;
            base = 16'h0100 + r * 16'h40;
            nw   = 24;
            for (int i = 0; i < nw - 1; i++) begin
                int k, tgt;
                k = $urandom_range(0, 9);
                if (k <= 6)
                    mem[base+i] = w($urandom_range(0, 4) == 0, 7'($urandom_range(0, 127)),
                                    8'($urandom_range(0, 7)), 16'($urandom()));
                else if (k == 7)
                    mem[base+i] = w(1'b0, 7'd0, 8'($urandom_range(8, 253)), 16'($urandom()));
                else begin
                    tgt = base + i + 1 + $urandom_range(0, 2);
                    if (tgt > base + nw - 1) tgt = base + nw - 1;
                    mem[base+i] = w(1'b0, 7'd0, 8'hFE, 16'(tgt));
                end
            end
            mem[base+nw-1] = HALT_W;

            exp_q.delete();
            exp_err = 1'b0;
            pc = base;
            for (int s = 0; s < 200; s++) begin
                wd = mem[pc];
                if (wd[23:16] == 8'hFF) break;
                if (wd[23:16] == 8'hFE) pc = wd[15:0];
                else begin
                    if (wd[23:16] >= 8) exp_err = 1'b1;
                    else begin
                        e.dir = wd[31]; e.ch = wd[23:16]; e.data = wd[15:0]; e.delay = wd[30:24];
                        exp_q.push_back(e);
                    end
                    pc = (pc + 1) % 65536;
                end
            end

            full_i = '0;
            start_at(16'(base));
            n = 0;
            while (!halted_o && n < 3000) begin
                if (valid_o != 0 || direct_o != 0) begin
                    ach = -1;
                    for (int i = 0; i < 8; i++) if (valid_o[i] | direct_o[i]) ach = i;
                    chk("rnd_onehot", 64'($countones(valid_o) + $countones(direct_o)), 64'd1);
                    if (exp_q.size() == 0) chk("rnd_extra_strobe", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rnd_strobe", {|direct_o, 8'(ach), data_o, delay_o},
                            {e.dir, 8'(e.ch), e.data, e.delay});
                    end
                    if (|valid_o && ach >= 0) chk("rnd_full_ok", 64'(full_i[ach]), 64'd0);
                end
                full_i = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
                tick();
                n++;
            end
            full_i = '0;
            chk("rnd_halted", 64'(halted_o), 64'd1);
            chk("rnd_drain", 64'(exp_q.size()), 64'd0);
            chk("rnd_err", 64'(err_o), 64'(exp_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
